intr_ctrl: RTL and testbench

Interrupt controller that consumes the `irq` outputs of the timer and other bus-slave peripherals and presents a single maskable interrupt request to the CPU. It latches rising edges of up to `IRQ_CH` request lines into a pending register, applies a per-channel mask and a global enable, and exposes a fixed-priority vector that software reads to acknowledge. It is a bus slave on the same `cs_`/`as_`/`rw`/`addr` bus as the timer, with the same registered `rdy_`/`rd_data` protocol.

---
 rtl/intr_ctrl.sv | 142 ++++++++++++++
 tb/tb_intr_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : intr_ctrl
//  Purpose  : Edge-latching interrupt controller with per-channel mask,
//             global enable and fixed-priority vector (channel 0 highest).
//             Bus slave with registered rdy_/rd_data.
//  Revision : 1.0  initial release
// ============================================================================
module intr_ctrl #(
  parameter int IRQ_CH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [1:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  input  logic [IRQ_CH-1:0] irq_in,
  output logic              cpu_irq
);

  localparam logic [1:0] c_ADDR_PEND = 2'd0;
  localparam logic [1:0] c_ADDR_MASK = 2'd1;
  localparam logic [1:0] c_ADDR_VECT = 2'd2;
  localparam logic [1:0] c_ADDR_CTRL = 2'd3;

  logic [IRQ_CH-1:0] r_irq_d;
  logic [IRQ_CH-1:0] r_pend;
  logic [IRQ_CH-1:0] r_mask;
  logic              r_gen;
  logic              r_cpu_irq;
  logic              r_rdy_n;
  logic [31:0]       r_rd_data;

  logic              w_access;
  logic              w_read;
  logic              w_write;
  logic [IRQ_CH-1:0] w_rise;
  logic [IRQ_CH-1:0] w_active;
  logic [IRQ_CH-1:0] w_lowest;
  logic              w_valid;
  logic [4:0]        w_idx;
  logic              w_vect_ack;
  logic [IRQ_CH-1:0] w_clr;
  logic [31:0]       w_pend_ext;
  logic [31:0]       w_mask_ext;
  logic [31:0]       w_rd_mux;
  logic              w_unused;

  assign w_access = !cs_ && !as_;
  assign w_read   = w_access && rw;
  assign w_write  = w_access && !rw;

  assign w_rise   = irq_in & ~r_irq_d;
  assign w_active = r_pend & ~r_mask;
  assign w_valid  = |w_active;

  // Wider data bits beyond the channel count are intentionally ignored.
  assign w_unused = &{1'b0, wr_data};

  // Priority encode: scanning downward leaves the lowest set channel winning.
  always_comb begin
    w_idx    = '0;
    w_lowest = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_idx       = 5'(i);
        w_lowest    = '0;
        w_lowest[i] = 1'b1;
      end
    end
  end

  // A VECT read only acknowledges when something is actually being reported.
  assign w_vect_ack = w_read && (addr == c_ADDR_VECT) && w_valid;

  // Clear sources: write-1-to-clear on PEND plus the acknowledged channel.
  always_comb begin
    w_clr = '0;
    if (w_write && (addr == c_ADDR_PEND)) begin
      w_clr = wr_data[IRQ_CH-1:0];
    end
    if (w_vect_ack) begin
      w_clr = w_clr | w_lowest;
    end
  end

  // Zero-extend channel-wide registers onto the 32-bit bus and pick the read view.
  always_comb begin
    w_pend_ext             = '0;
    w_mask_ext             = '0;
    w_pend_ext[IRQ_CH-1:0] = r_pend;
    w_mask_ext[IRQ_CH-1:0] = r_mask;
    case (addr)
      c_ADDR_PEND: w_rd_mux = w_pend_ext;
      c_ADDR_MASK: w_rd_mux = w_mask_ext;
      c_ADDR_VECT: w_rd_mux = {w_valid, 26'b0, w_idx};
      default:     w_rd_mux = {31'b0, r_gen};
    endcase
  end

  // Interrupt state: edge history, pending (set beats clear), mask and enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_d   <= '0;
      r_pend    <= '0;
      r_mask    <= '1;
      r_gen     <= 1'b0;
      r_cpu_irq <= 1'b0;
    end else begin
      r_irq_d   <= irq_in;
      r_pend    <= (r_pend & ~w_clr) | w_rise;
      r_cpu_irq <= r_gen && w_valid;
      if (w_write && (addr == c_ADDR_MASK)) begin
        r_mask <= wr_data[IRQ_CH-1:0];
      end
      if (w_write && (addr == c_ADDR_CTRL)) begin
        r_gen <= wr_data[0];
      end
    end
  end

  // Bus response: one-cycle rdy_ pulse per access, read data only while rdy_ is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_n   <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_rdy_n   <= !w_access;
      r_rd_data <= w_read ? w_rd_mux : 32'h0;
    end
  end

  assign rd_data = r_rd_data;
  assign rdy_    = r_rdy_n;
  assign cpu_irq = r_cpu_irq;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intr_ctrl
//  Purpose  : Self-checking bench for intr_ctrl: reset and mid-access reset
//             sequences, a directed vector table, and randomized traffic
//             compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_cs;
  logic        t_as;
  logic        t_rw;
  logic [1:0]  t_addr;
  logic [31:0] t_wd;
  logic [7:0]  t_irq;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        cpu_irq;

  int n_checks = 0;
  int n_errors = 0;

  intr_ctrl #(.IRQ_CH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_     (t_cs),
    .as_     (t_as),
    .rw      (t_rw),
    .addr    (t_addr),
    .wr_data (t_wd),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq_in  (t_irq),
    .cpu_irq (cpu_irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state: pending/mask as bit sets, enable, last input level.
  logic [7:0]  m_pend;
  logic [7:0]  m_mask;
  logic        m_gen;
  logic [7:0]  m_prev;
  logic        m_rdy;
  logic [31:0] m_rd;
  logic        m_cpu;

  typedef struct {
    logic        cs;
    logic        as_n;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [7:0]  irq;
    logic        e_rdy;
    logic [31:0] e_rd;
    logic        e_cpu;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cs, input logic as_n, input logic rw,
                              input logic [1:0] a, input logic [31:0] wd,
                              input logic [7:0] irq, input logic e_rdy,
                              input logic [31:0] e_rd, input logic e_cpu);
    vec_t v;
    v.cs = cs; v.as_n = as_n; v.rw = rw; v.addr = a; v.wd = wd; v.irq = irq;
    v.e_rdy = e_rdy; v.e_rd = e_rd; v.e_cpu = e_cpu;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic e_rdy, input logic [31:0] e_rd,
                      input logic e_cpu);
    check({name, ".rdy_"}, {31'b0, rdy_}, {31'b0, e_rdy});
    check({name, ".rd_data"}, rd_data, e_rd);
    check({name, ".cpu_irq"}, {31'b0, cpu_irq}, {31'b0, e_cpu});
  endtask

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'hFF; m_gen = 1'b0; m_prev = 8'h00;
    m_rdy = 1'b1; m_rd = 32'h0; m_cpu = 1'b0;
  endtask

  // One clock of the model, evaluated from the state before the edge.
  task automatic model_step(input logic cs, input logic as_n, input logic rw,
                            input logic [1:0] a, input logic [31:0] wd,
                            input logic [7:0] irq);
    logic acc, rd, wr, valid;
    int   first;
    logic [7:0] nxt;
    acc   = !cs && !as_n;
    rd    = acc && rw;
    wr    = acc && !rw;
    first = -1;
    for (int i = 0; i < 8; i++)
      if (first < 0 && m_pend[i] && !m_mask[i]) first = i;
    valid = (first >= 0);
    m_rdy = !acc;
    m_cpu = m_gen && valid;
    m_rd  = 32'h0;
    if (rd) begin
      case (a)
        2'd0: m_rd = {24'h0, m_pend};
        2'd1: m_rd = {24'h0, m_mask};
        2'd2: m_rd = valid ? (32'h8000_0000 + 32'(first)) : 32'h0;
        default: m_rd = {31'h0, m_gen};
      endcase
    end
    for (int i = 0; i < 8; i++) begin
      if (irq[i] && !m_prev[i])                   nxt[i] = 1'b1;
      else if (wr && a == 2'd0 && wd[i])          nxt[i] = 1'b0;
      else if (rd && a == 2'd2 && valid && i == first) nxt[i] = 1'b0;
      else                                        nxt[i] = m_pend[i];
    end
    m_pend = nxt;
    if (wr && a == 2'd1) m_mask = wd[7:0];
    if (wr && a == 2'd3) m_gen  = wd[0];
    m_prev = irq;
  endtask

  // Drive one cycle of bus/irq inputs at negedge, advance the model at posedge.
  task automatic cycle(input logic cs, input logic as_n, input logic rw,
                       input logic [1:0] a, input logic [31:0] wd, input logic [7:0] irq);
    @(negedge clk);
    t_cs = cs; t_as = as_n; t_rw = rw; t_addr = a; t_wd = wd; t_irq = irq;
    @(posedge clk);
    model_step(cs, as_n, rw, a, wd, irq);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    t_cs = 1'b1; t_as = 1'b1; t_rw = 1'b0; t_addr = 2'd0; t_wd = 32'h0;
    t_irq = 8'hFF;
    model_reset();

    // Reset held with all request lines high.
    repeat (3) @(posedge clk);
    #1;
    chk3("in_reset", 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Lines high out of reset latch pending; MASK reads its reset value.
    cycle(0, 0, 1, 2'd1, 32'h0, 8'hFF);
    chk3("rst_mask_read", 1'b0, 32'h0000_00FF, 1'b0);
    cycle(0, 0, 0, 2'd1, 32'h0, 8'hFF);
    cycle(0, 0, 0, 2'd3, 32'h1, 8'hFF);
    cycle(1, 1, 0, 2'd0, 32'h0, 8'hFF);
    chk3("pre_midrst", 1'b1, 32'h0, 1'b1);

    // Reset dropped in the middle of a VECT read.
    @(negedge clk);
    t_cs = 0; t_as = 0; t_rw = 1; t_addr = 2'd2; t_irq = 8'h00;
    #2 reset = 1'b0;
    #1;
    chk3("midrst_async", 1'b1, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk3("midrst_edge", 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    t_cs = 1; t_as = 1;
    reset = 1'b1;
    model_reset();
    cycle(0, 0, 1, 2'd0, 32'h0, 8'h00);
    chk3("midrst_pend", 1'b0, 32'h0, 1'b0);
    cycle(1, 1, 0, 2'd0, 32'h0, 8'h00);

    // Directed vectors: cs_, as_, rw, addr, wr_data, irq_in -> rdy_, rd_data, cpu_irq.
    tbl.push_back(mk(0,0,1,2'd1,32'h0,       8'h00, 0, 32'h0000_00FF, 0)); // 0 read MASK
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h00, 1, 32'h0,         0)); // 1 idle
    tbl.push_back(mk(0,0,0,2'd1,32'h0,       8'h00, 0, 32'h0,         0)); // 2 MASK=0
    tbl.push_back(mk(0,0,0,2'd3,32'h1,       8'h00, 0, 32'h0,         0)); // 3 CTRL=1
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h08, 1, 32'h0,         0)); // 4 rise ch3
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h00, 1, 32'h0,         1)); // 5 cpu_irq up
    tbl.push_back(mk(0,0,1,2'd2,32'h0,       8'h00, 0, 32'h8000_0003, 1)); // 6 VECT ack
    tbl.push_back(mk(0,0,1,2'd0,32'h0,       8'h00, 0, 32'h0,         0)); // 7 PEND empty
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h24, 1, 32'h0,         0)); // 8 rise ch5+ch2
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h00, 1, 32'h0,         1)); // 9
    tbl.push_back(mk(0,0,1,2'd2,32'h0,       8'h00, 0, 32'h8000_0002, 1)); // 10
    tbl.push_back(mk(0,0,1,2'd2,32'h0,       8'h00, 0, 32'h8000_0005, 1)); // 11
    tbl.push_back(mk(0,0,1,2'd2,32'h0,       8'h00, 0, 32'h0,         0)); // 12 empty VECT
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h00, 1, 32'h0,         0)); // 13
    tbl.push_back(mk(0,0,0,2'd1,32'h8,       8'h00, 0, 32'h0,         0)); // 14 MASK=08
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h08, 1, 32'h0,         0)); // 15 masked rise
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h00, 1, 32'h0,         0)); // 16
    tbl.push_back(mk(0,0,1,2'd0,32'h0,       8'h00, 0, 32'h0000_0008, 0)); // 17 still pending
    tbl.push_back(mk(0,0,0,2'd1,32'h0,       8'h00, 0, 32'h0,         0)); // 18 unmask
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h00, 1, 32'h0,         1)); // 19
    tbl.push_back(mk(0,0,0,2'd3,32'h0,       8'h00, 0, 32'h0,         1)); // 20 CTRL=0
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h00, 1, 32'h0,         0)); // 21
    tbl.push_back(mk(0,0,1,2'd3,32'h0,       8'h00, 0, 32'h0,         0)); // 22 read CTRL
    tbl.push_back(mk(0,0,1,2'd2,32'h0,       8'h00, 0, 32'h8000_0003, 0)); // 23 VECT w/ gen=0
    tbl.push_back(mk(0,0,1,2'd0,32'h0,       8'h00, 0, 32'h0,         0)); // 24
    tbl.push_back(mk(0,0,0,2'd0,32'h1,       8'h01, 0, 32'h0,         0)); // 25 set beats clear
    tbl.push_back(mk(0,0,1,2'd0,32'h0,       8'h01, 0, 32'h0000_0001, 0)); // 26
    tbl.push_back(mk(0,0,0,2'd0,32'h1,       8'h01, 0, 32'h0,         0)); // 27 clear, level held
    tbl.push_back(mk(0,0,1,2'd0,32'h0,       8'h01, 0, 32'h0,         0)); // 28 no re-set
    tbl.push_back(mk(1,1,0,2'd0,32'h0,       8'h00, 1, 32'h0,         0)); // 29
    tbl.push_back(mk(0,0,0,2'd3,32'hFFFF_FFFE,8'h00,0, 32'h0,         0)); // 30 gen=0
    tbl.push_back(mk(0,0,1,2'd3,32'h0,       8'h00, 0, 32'h0,         0)); // 31
    tbl.push_back(mk(0,0,0,2'd3,32'h3,       8'h00, 0, 32'h0,         0)); // 32 gen=1
    tbl.push_back(mk(0,0,1,2'd3,32'h0,       8'h00, 0, 32'h0000_0001, 0)); // 33
    tbl.push_back(mk(0,1,1,2'd1,32'h0,       8'h00, 1, 32'h0,         0)); // 34 as_ high
    tbl.push_back(mk(1,0,1,2'd1,32'h0,       8'h00, 1, 32'h0,         0)); // 35 cs_ high
    tbl.push_back(mk(0,0,0,2'd2,32'hFFFF_FFFF,8'h00,0, 32'h0,         0)); // 36 VECT write
    tbl.push_back(mk(0,0,1,2'd1,32'h0,       8'h00, 0, 32'h0,         0)); // 37
    tbl.push_back(mk(0,0,0,2'd1,32'hFFFF_FF5A,8'h00,0, 32'h0,         0)); // 38
    tbl.push_back(mk(0,0,1,2'd1,32'h0,       8'h00, 0, 32'h0000_005A, 0)); // 39
    tbl.push_back(mk(0,0,0,2'd3,32'h0,       8'h00, 0, 32'h0,         0)); // 40 gen=0

    foreach (tbl[k]) begin
      cycle(tbl[k].cs, tbl[k].as_n, tbl[k].rw, tbl[k].addr, tbl[k].wd, tbl[k].irq);
      chk3($sformatf("vec%0d", k), tbl[k].e_rdy, tbl[k].e_rd, tbl[k].e_cpu);
    end

    // Randomized traffic against the behavioural model.
    begin
      logic [7:0] irq_r;
      irq_r = 8'h00;
      for (int n = 0; n < 800; n++) begin
        logic cs, as_n, rw;
        logic [1:0] a;
        logic [31:0] wd;
        cs    = ($urandom_range(0, 3) == 0);
        as_n  = ($urandom_range(0, 5) == 0);
        rw    = ($urandom_range(0, 2) != 0);
        a     = 2'($urandom_range(0, 3));
        wd    = $urandom;
        if (a == 2'd1 && $urandom_range(0, 1) == 1) wd = {wd[31:8], wd[7:0] & wd[15:8]};
        irq_r = irq_r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        cycle(cs, as_n, rw, a, wd, irq_r);
        chk3($sformatf("rnd%0d", n), m_rdy, m_rd, m_cpu);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
